// File: rtl/dmem_pkg.sv
// Shared definitions for the data-cache block memory: controller state
// encoding, block width and default configuration constants.
package dmem_pkg;

    localparam int BLOCK_W            = 128;
    localparam int DEFAULT_ADDR_W     = 28;
    localparam int DEFAULT_DEPTH_LOG2 = 8;
    localparam int DEFAULT_LATENCY    = 4;
    localparam int CNT_W              = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/dcache_block_memory_array.sv
// Synchronous single-port block storage. The read register only changes on a
// read access, so returned data stays stable between reads.
import dmem_pkg::*;

module dcache_block_memory_array #(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] index,
    input  logic [BLOCK_W-1:0]    wdata,
    output logic [BLOCK_W-1:0]    rdata
);

    logic [BLOCK_W-1:0] storage [2**DEPTH_LOG2];

    // Contents survive reset; only the read-out register is cleared.
    always_ff @(posedge clock) begin
        if (en && we) begin
            storage[index] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= storage[index];
        end
    end

endmodule

// File: rtl/dcache_block_memory.sv
// Multi-cycle block memory behind the data cache's memory-side port.
// Optional feature macro: DCACHE_BLOCK_MEMORY_PERF_COUNTERS_EN (read/write commit counters).
import dmem_pkg::*;

module dcache_block_memory #(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int LATENCY    = DEFAULT_LATENCY
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [ADDR_W-1:0]  mem_address,
    input  logic [BLOCK_W-1:0] mem_writedata,
    output logic [BLOCK_W-1:0] mem_readdata,
    output logic               mem_busywait
`ifdef DCACHE_BLOCK_MEMORY_PERF_COUNTERS_EN
    ,
    output logic [31:0]        read_count,
    output logic [31:0]        write_count
`endif
);

    dmem_state_t           state;
    logic [CNT_W-1:0]      counter;
    logic                  op_write;
    logic [DEPTH_LOG2-1:0] index_q;
    logic [BLOCK_W-1:0]    wdata_q;
    logic                  req;
    logic                  commit;
    logic                  unused_addr_bits;

    // Upper block-address bits alias onto the stored range.
    assign unused_addr_bits = ^mem_address[ADDR_W-1:DEPTH_LOG2];

    assign req          = mem_read | mem_write;
    assign mem_busywait = reset & req & (state != ACK);
    assign commit       = (state == ACCESS) && (counter == '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            counter  <= '0;
            op_write <= 1'b0;
            index_q  <= '0;
            wdata_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= mem_write;
                        index_q  <= mem_address[DEPTH_LOG2-1:0];
                        wdata_q  <= mem_writedata;
                        counter  <= CNT_W'(LATENCY - 1);
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (counter == '0) begin
                        state <= ACK;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    dcache_block_memory_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clock(clock),
        .reset(reset),
        .en   (commit),
        .we   (op_write),
        .index(index_q),
        .wdata(wdata_q),
        .rdata(mem_readdata)
    );

`ifdef DCACHE_BLOCK_MEMORY_PERF_COUNTERS_EN
    // Commit counters saturate rather than wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (commit) begin
            if (op_write) begin
                if (write_count != 32'hFFFF_FFFF) begin
                    write_count <= write_count + 32'd1;
                end
            end else begin
                if (read_count != 32'hFFFF_FFFF) begin
                    read_count <= read_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule
